// File: rtl/tvip_axi_burst_address_generator.sv
// ---------------------------------------------------------------------------
// tvip_axi_burst_address_generator
//
// Purpose: accepts one AXI-style burst request at a time and expands it into
// a stream of beats. Each beat carries its byte address, active byte lanes,
// beat number and last flag. An illegal request is reported as a single
// error beat with no active byte lanes.
//
// Ports:
//   aclk, areset                  clock, async active-high reset
//   req_valid / req_ready         request handshake
//   req_id, req_address,
//   req_length, req_size,
//   req_burst                     request fields (AXI AxID/AxADDR/AxLEN/
//                                 AxSIZE/AxBURST encodings)
//   beat_valid / beat_ready       per-beat handshake
//   beat_id, beat_address,
//   beat_strobe, beat_index,
//   beat_last, beat_error         per-beat outputs, all registered
//
// State  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no burst in progress, waiting for a request
// BURST  | beat_valid is high, beats are being presented
// ---------------------------------------------------------------------------
module tvip_axi_burst_address_generator #(
  parameter int ADDRESS_WIDTH = 64,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 8
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ID_WIDTH-1:0]       req_id,
  input  logic [ADDRESS_WIDTH-1:0]  req_address,
  input  logic [7:0]                req_length,
  input  logic [2:0]                req_size,
  input  logic [1:0]                req_burst,
  output logic                      beat_valid,
  input  logic                      beat_ready,
  output logic [ID_WIDTH-1:0]       beat_id,
  output logic [ADDRESS_WIDTH-1:0]  beat_address,
  output logic [DATA_WIDTH/8-1:0]   beat_strobe,
  output logic [7:0]                beat_index,
  output logic                      beat_last,
  output logic                      beat_error
);

  localparam int AW       = ADDRESS_WIDTH;
  localparam int NB       = DATA_WIDTH / 8;
  localparam int SIZE_MAX = $clog2(NB);
  localparam logic [AW-1:0] ONE       = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] LANE_MASK = AW'(NB - 1);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t               r_state;
  logic [AW-1:0]        r_start;
  logic [7:0]           r_length;
  logic [2:0]           r_size;
  logic [1:0]           r_burst;
  logic [ID_WIDTH-1:0]  r_id;
  logic [AW-1:0]        r_addr;
  logic [NB-1:0]        r_strobe;
  logic [7:0]           r_index;
  logic                 r_last;
  logic                 r_error;

  // Lanes run from the (possibly unaligned) address lane up to the end of
  // the size-aligned container that holds it.
  function automatic logic [NB-1:0] lane_strobe(input logic [AW-1:0] a,
                                                input logic [2:0]    s);
    logic [AW-1:0] sb;
    logic [AW-1:0] lo;
    logic [AW-1:0] hi;
    logic [NB-1:0] strb;
    sb = ONE << s;
    lo = a & LANE_MASK;
    hi = ((a & ~(sb - ONE)) & LANE_MASK) + sb - ONE;
    for (int i = 0; i < NB; i++) begin
      strb[i] = (AW'(i) >= lo) && (AW'(i) <= hi);
    end
    return strb;
  endfunction

  // Request legality
  logic [AW-1:0] w_req_sb;
  logic [8:0]    w_req_beats;
  logic [16:0]   w_incr_end;
  logic          w_size_bad;
  logic          w_wrap_len_bad;
  logic          w_unaligned;
  logic          w_req_error;

  always_comb begin
    w_req_sb       = ONE << req_size;
    w_req_beats    = {1'b0, req_length} + 9'd1;
    w_size_bad     = int'(req_size) > SIZE_MAX;
    w_wrap_len_bad = !((req_length == 8'd1) || (req_length == 8'd3) ||
                       (req_length == 8'd7) || (req_length == 8'd15));
    w_unaligned    = (req_address & (w_req_sb - ONE)) != '0;
    // End of an INCR burst inside its 4KB page, wide enough not to overflow
    w_incr_end     = {5'b0, req_address[11:0] & ~(w_req_sb[11:0] - 12'd1)} +
                     ({8'b0, w_req_beats} << req_size);
    w_req_error    = w_size_bad ||
                     (req_burst == 2'b11) ||
                     ((req_burst == BURST_WRAP)  && (w_wrap_len_bad || w_unaligned)) ||
                     ((req_burst == BURST_FIXED) && (req_length > 8'd15)) ||
                     ((req_burst == BURST_INCR)  && (w_incr_end > 17'd4096));
  end

  // Next beat address from the registered burst
  logic [AW-1:0] w_sb;
  logic [AW-1:0] w_wrap_bytes;
  logic [AW-1:0] w_boundary;
  logic [AW-1:0] w_wrap_step;
  logic [AW-1:0] w_next_addr;

  always_comb begin
    w_sb         = ONE << r_size;
    w_wrap_bytes = {{(AW-9){1'b0}}, ({1'b0, r_length} + 9'd1)} << r_size;
    w_boundary   = r_start & ~(w_wrap_bytes - ONE);
    w_wrap_step  = r_addr + w_sb;
    w_next_addr  = r_start;
    case (r_burst)
      BURST_INCR: w_next_addr = (r_addr & ~(w_sb - ONE)) + w_sb;
      BURST_WRAP: w_next_addr = (w_wrap_step == (w_boundary + w_wrap_bytes)) ?
                                w_boundary : w_wrap_step;
      default:    w_next_addr = r_start;
    endcase
  end

  logic w_beat_hs;
  logic w_accept;

  assign beat_valid   = (r_state == ST_BURST);
  assign w_beat_hs    = beat_valid & beat_ready;
  assign req_ready    = (r_state == ST_IDLE) | (w_beat_hs & r_last);
  assign w_accept     = req_valid & req_ready;

  assign beat_id      = r_id;
  assign beat_address = r_addr;
  assign beat_strobe  = r_strobe;
  assign beat_index   = r_index;
  assign beat_last    = r_last;
  assign beat_error   = r_error;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state  <= ST_IDLE;
      r_start  <= '0;
      r_length <= '0;
      r_size   <= '0;
      r_burst  <= '0;
      r_id     <= '0;
      r_addr   <= '0;
      r_strobe <= '0;
      r_index  <= '0;
      r_last   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      // A new request wins over the last-beat retire so back-to-back
      // bursts continue without a bubble.
      if (w_accept) begin
        r_state  <= ST_BURST;
        r_start  <= req_address;
        r_length <= req_length;
        r_size   <= req_size;
        r_burst  <= req_burst;
        r_id     <= req_id;
        r_addr   <= req_address;
        r_index  <= 8'd0;
        r_error  <= w_req_error;
        r_last   <= w_req_error | (req_length == 8'd0);
        r_strobe <= w_req_error ? '0 : lane_strobe(req_address, req_size);
      end else if (w_beat_hs) begin
        if (r_last) begin
          r_state <= ST_IDLE;
        end else begin
          r_index  <= r_index + 8'd1;
          r_last   <= (r_index + 8'd1) == r_length;
          r_addr   <= w_next_addr;
          r_strobe <= lane_strobe(w_next_addr, r_size);
        end
      end
    end
  end

endmodule

// File: tb/tb_tvip_axi_burst_address_generator.sv
module tb_tvip_axi_burst_address_generator;

  logic        aclk = 1'b0;
  logic        areset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_id;
  logic [63:0] req_address;
  logic [7:0]  req_length;
  logic [2:0]  req_size;
  logic [1:0]  req_burst;
  logic        beat_valid;
  logic        beat_ready;
  logic [7:0]  beat_id;
  logic [63:0] beat_address;
  logic [3:0]  beat_strobe;
  logic [7:0]  beat_index;
  logic        beat_last;
  logic        beat_error;

  int errors = 0;
  int checks = 0;

  tvip_axi_burst_address_generator #(
    .ADDRESS_WIDTH(64), .DATA_WIDTH(32), .ID_WIDTH(8)
  ) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .req_address(req_address), .req_length(req_length), .req_size(req_size),
    .req_burst(req_burst),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_id(beat_id),
    .beat_address(beat_address), .beat_strobe(beat_strobe),
    .beat_index(beat_index), .beat_last(beat_last), .beat_error(beat_error)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [7:0]       id;
    logic             err;
    logic [3:0][63:0] ea;
    logic [3:0][3:0]  es;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic [7:0] id, input logic err,
                         input logic [63:0] a0, input logic [63:0] a1,
                         input logic [63:0] a2, input logic [63:0] a3,
                         input logic [3:0] s0, input logic [3:0] s1,
                         input logic [3:0] s2, input logic [3:0] s3);
    vec_t v;
    v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.id = id; v.err = err;
    v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3;
    v.es[0] = s0; v.es[1] = s1; v.es[2] = s2; v.es[3] = s3;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [63:0] addr,
                          input logic [3:0] strb, input logic [7:0] idx,
                          input logic last, input logic err, input logic [7:0] id);
    chk({tag, ".valid"}, 64'(beat_valid), 64'(1'b1));
    chk({tag, ".addr"},  beat_address, addr);
    chk({tag, ".strb"},  64'(beat_strobe), 64'(strb));
    chk({tag, ".index"}, 64'(beat_index), 64'(idx));
    chk({tag, ".last"},  64'(beat_last), 64'(last));
    chk({tag, ".error"}, 64'(beat_error), 64'(err));
    chk({tag, ".id"},    64'(beat_id), 64'(id));
  endtask

  task automatic drive_req(input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [7:0] id);
    req_valid   = 1'b1;
    req_address = addr;
    req_length  = len;
    req_size    = size;
    req_burst   = burst;
    req_id      = id;
  endtask

  initial begin
    // addr, len, size, burst, id, err, addresses, strobes
    add_vec(64'h1002, 8'd3, 3'd2, 2'b01, 8'h11, 1'b0,
            64'h1002, 64'h1004, 64'h1008, 64'h100C, 4'b1100, 4'b1111, 4'b1111, 4'b1111);
    add_vec(64'h34, 8'd3, 3'd2, 2'b10, 8'h12, 1'b0,
            64'h34, 64'h38, 64'h3C, 64'h30, 4'b1111, 4'b1111, 4'b1111, 4'b1111);
    add_vec(64'h101, 8'd2, 3'd0, 2'b00, 8'h13, 1'b0,
            64'h101, 64'h101, 64'h101, 64'h0, 4'b0010, 4'b0010, 4'b0010, 4'b0000);
    add_vec(64'h40, 8'd2, 3'd2, 2'b10, 8'h14, 1'b1,
            64'h40, 64'h0, 64'h0, 64'h0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_vec(64'hFF8, 8'd3, 3'd2, 2'b01, 8'h15, 1'b1,
            64'hFF8, 64'h0, 64'h0, 64'h0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_vec(64'h100, 8'd0, 3'd3, 2'b01, 8'h16, 1'b1,
            64'h100, 64'h0, 64'h0, 64'h0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_vec(64'h200, 8'd1, 3'd2, 2'b11, 8'h17, 1'b1,
            64'h200, 64'h0, 64'h0, 64'h0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_vec(64'h7, 8'd1, 3'd0, 2'b01, 8'h18, 1'b0,
            64'h7, 64'h8, 64'h0, 64'h0, 4'b1000, 4'b0001, 4'b0000, 4'b0000);
    add_vec(64'h102, 8'd1, 3'd1, 2'b01, 8'h19, 1'b0,
            64'h102, 64'h104, 64'h0, 64'h0, 4'b1100, 4'b0011, 4'b0000, 4'b0000);
    add_vec(64'h6, 8'd1, 3'd1, 2'b10, 8'h1A, 1'b0,
            64'h6, 64'h4, 64'h0, 64'h0, 4'b1100, 4'b0011, 4'b0000, 4'b0000);
    add_vec(64'hFF0, 8'd3, 3'd2, 2'b01, 8'h1B, 1'b0,
            64'hFF0, 64'hFF4, 64'hFF8, 64'hFFC, 4'b1111, 4'b1111, 4'b1111, 4'b1111);
    add_vec(64'h35, 8'd3, 3'd2, 2'b10, 8'h1C, 1'b1,
            64'h35, 64'h0, 64'h0, 64'h0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_vec(64'h500, 8'd16, 3'd0, 2'b00, 8'h1D, 1'b1,
            64'h500, 64'h0, 64'h0, 64'h0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    areset      = 1'b1;
    req_valid   = 1'b0;
    req_id      = '0;
    req_address = '0;
    req_length  = '0;
    req_size    = '0;
    req_burst   = '0;
    beat_ready  = 1'b1;

    repeat (3) @(negedge aclk);
    chk("rst.valid",  64'(beat_valid), 64'(1'b0));
    chk("rst.addr",   beat_address, 64'h0);
    chk("rst.strb",   64'(beat_strobe), 64'(4'b0000));
    chk("rst.index",  64'(beat_index), 64'(8'd0));
    chk("rst.last",   64'(beat_last), 64'(1'b0));
    chk("rst.error",  64'(beat_error), 64'(1'b0));
    chk("rst.id",     64'(beat_id), 64'(8'd0));
    areset = 1'b0;
    @(negedge aclk);
    chk("rst.req_ready_after", 64'(req_ready), 64'(1'b1));

    // Table-driven bursts, beat_ready held high
    for (int v = 0; v < vecs.size(); v++) begin
      int nb;
      nb = vecs[v].err ? 1 : int'(vecs[v].len) + 1;
      @(negedge aclk);
      drive_req(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, vecs[v].id);
      #1;
      chk($sformatf("v%0d.req_ready", v), 64'(req_ready), 64'(1'b1));
      @(posedge aclk);
      #1 req_valid = 1'b0;
      for (int b = 0; b < nb; b++) begin
        @(negedge aclk);
        chk_beat($sformatf("v%0d.b%0d", v, b), vecs[v].ea[b], vecs[v].es[b],
                 8'(b), (b == nb - 1), vecs[v].err, vecs[v].id);
      end
      @(negedge aclk);
      chk($sformatf("v%0d.no_extra", v), 64'(beat_valid), 64'(1'b0));
    end

    // Backpressure at beat 1, then a back-to-back request on the last beat
    @(negedge aclk);
    drive_req(64'h200, 8'd3, 3'd2, 2'b01, 8'h21);
    @(posedge aclk);
    #1 req_valid = 1'b0;
    @(negedge aclk);
    chk_beat("bp.b0", 64'h200, 4'b1111, 8'd0, 1'b0, 1'b0, 8'h21);
    @(negedge aclk);
    chk_beat("bp.b1", 64'h204, 4'b1111, 8'd1, 1'b0, 1'b0, 8'h21);
    beat_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      chk_beat($sformatf("bp.hold%0d", c), 64'h204, 4'b1111, 8'd1, 1'b0, 1'b0, 8'h21);
      chk($sformatf("bp.hold%0d.req_ready", c), 64'(req_ready), 64'(1'b0));
    end
    beat_ready = 1'b1;
    @(negedge aclk);
    chk_beat("bp.b2", 64'h208, 4'b1111, 8'd2, 1'b0, 1'b0, 8'h21);
    @(negedge aclk);
    chk_beat("bp.b3", 64'h20C, 4'b1111, 8'd3, 1'b1, 1'b0, 8'h21);
    drive_req(64'h101, 8'd0, 3'd0, 2'b00, 8'h22);
    #1;
    chk("b2b.req_ready_on_last", 64'(req_ready), 64'(1'b1));
    @(posedge aclk);
    #1 req_valid = 1'b0;
    @(negedge aclk);
    chk_beat("b2b.b0", 64'h101, 4'b0010, 8'd0, 1'b1, 1'b0, 8'h22);
    @(negedge aclk);
    chk("b2b.no_extra", 64'(beat_valid), 64'(1'b0));

    // Reset pulse during beat 2 of a 4-beat INCR
    @(negedge aclk);
    drive_req(64'h300, 8'd3, 3'd2, 2'b01, 8'h31);
    @(posedge aclk);
    #1 req_valid = 1'b0;
    @(negedge aclk);
    chk_beat("rb.b0", 64'h300, 4'b1111, 8'd0, 1'b0, 1'b0, 8'h31);
    @(negedge aclk);
    chk_beat("rb.b1", 64'h304, 4'b1111, 8'd1, 1'b0, 1'b0, 8'h31);
    @(negedge aclk);
    chk_beat("rb.b2", 64'h308, 4'b1111, 8'd2, 1'b0, 1'b0, 8'h31);
    areset = 1'b1;
    #1;
    chk("rb.valid_async",  64'(beat_valid), 64'(1'b0));
    chk("rb.addr_async",   beat_address, 64'h0);
    chk("rb.index_async",  64'(beat_index), 64'(8'd0));
    chk("rb.strb_async",   64'(beat_strobe), 64'(4'b0000));
    @(negedge aclk);
    areset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge aclk);
      chk($sformatf("rb.post%0d.valid", c), 64'(beat_valid), 64'(1'b0));
      chk($sformatf("rb.post%0d.req_ready", c), 64'(req_ready), 64'(1'b1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
